rx_display_sequencer: RTL
=========================

Name: rx_display_sequencer

Overview:
- Sits between the UART receiver and the four-digit LED driver.
- Assembles consecutive received bytes into 16-bit display words, high byte first, and loads each completed word into the register that drives signal_to_display.
- Replaces the displayed value with a fixed error pattern on a parity or framing error.
- Discards half-received words after an inter-byte timeout, and keeps word and error statistics.

Parameters:
- TIMEOUT_CYCLES, 1024: the maximum number of clk cycles allowed between the high byte and the low byte (range 2 to 65535).
- ERROR_PATTERN, 16'hEEEE: the value loaded into signal_to_display on a receive error.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe marking a received byte.
- rx_perror  input  1  parity error for the byte; qualified by rx_valid.
- rx_ferror  input  1  framing error for the byte; qualified by rx_valid.
- clear  input  1  synchronous clear of the display and the statistics.
- signal_to_display  output  16  registered word sent to the LED driver; [15:12] is the leftmost digit.
- display_update  output  1  registered one-cycle pulse when signal_to_display changes source.
- error_flag  output  1  high while the displayed value is ERROR_PATTERN.
- timeout_pulse  output  1  registered one-cycle pulse when a partial word is discarded.
- word_count  output  8  number of committed good words; wraps from 255 to 0.
- err_count  output  8  number of error events; saturates at 255.

Behaviour:
- Reset (synchronous, with the highest priority) sets:
  - state=IDLE;
  - signal_to_display=16'h0000;
  - display_update=0, error_flag=0, timeout_pulse=0;
  - word_count=0, err_count=0;
  - the high-byte holding register=0;
  - timer=0.
- clear (next-highest priority) has the same effect as reset. A byte strobed in the same cycle as clear is dropped.
- An "error byte" means rx_valid=1 and (rx_perror=1 or rx_ferror=1).
- FSM states are IDLE, WAIT_LOW, COMMIT and ERROR:
  - IDLE:
    - good byte: hi_reg<=rx_data; timer<=0; next state WAIT_LOW;
    - error byte: next state ERROR;
    - otherwise: stay in IDLE.
  - WAIT_LOW:
    - good byte: lo_reg<=rx_data; next state COMMIT;
    - error byte: next state ERROR, and the high byte is discarded;
    - no byte and timer==TIMEOUT_CYCLES-1: next state IDLE, timeout_pulse<=1, high byte discarded;
    - otherwise: timer<=timer+1.
    - A byte arriving in the timeout cycle takes precedence over the timeout.
  - COMMIT (one cycle):
    - signal_to_display<={hi_reg,lo_reg}; display_update<=1; error_flag<=0; word_count<=word_count+1.
    - An incoming byte in this cycle is handled exactly as in IDLE (good byte goes to WAIT_LOW, error byte goes to ERROR); otherwise next state IDLE.
  - ERROR (one cycle):
    - signal_to_display<=ERROR_PATTERN; display_update<=1; error_flag<=1; err_count<=min(err_count+1,255).
    - An incoming byte is handled as in IDLE. Consecutive error bytes re-enter ERROR, and each one counts.
- Latency: if the low byte is strobed at rising edge k, the new word and display_update=1 are visible during the cycle after edge k+1.
- display_update and timeout_pulse are high for exactly one cycle per event and are 0 otherwise.
- The timer is 16 bits wide and counts only in WAIT_LOW.
- The displayed value holds indefinitely. A timeout does not change signal_to_display or error_flag.
- rx_perror and rx_ferror are ignored when rx_valid=0.

Test Plan:
1. Reset, then bytes 0x12 and 0x34 spaced 10 cycles apart -> signal_to_display=16'h1234 two edges after the 0x34 strobe; display_update is a single one-cycle pulse; word_count=1; error_flag=0.
2. Byte 0xAB, then no byte for TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=16 in the bench) -> exactly one timeout_pulse; display unchanged; a following 0xCD, 0xEF pair displays 16'hCDEF.
3. Byte 0x55 followed by a byte with rx_ferror=1 -> signal_to_display=16'hEEEE; error_flag=1; err_count=1; a following good pair 0x0F, 0xF0 gives 16'h0FF0 with error_flag=0.
4. Low byte strobed exactly in the timeout cycle (timer=TIMEOUT_CYCLES-1) -> the word commits and there is no timeout_pulse.
5. Back-to-back pairs with the next high byte strobed in the COMMIT cycle -> no byte lost; display shows 16'h1122 then 16'h3344; word_count=2.
6. 300 consecutive error bytes, then clear asserted mid-WAIT_LOW -> err_count holds at 255 before the clear; after the clear all outputs return to their reset values and state is IDLE.

Source files
------------

// File: rtl/rx_display_sequencer_if.sv
// Receive-side strobe bus from the UART plus the display/statistics outputs
// presented to the LED driver; master drives received bytes, slave sequences them.
interface rx_display_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_perror;
    logic        rx_ferror;
    logic [15:0] signal_to_display;
    logic        display_update;
    logic        error_flag;
    logic        timeout_pulse;
    logic [7:0]  word_count;
    logic [7:0]  err_count;

    modport master (
        output rx_data, rx_valid, rx_perror, rx_ferror,
        input  signal_to_display, display_update, error_flag,
        input  timeout_pulse, word_count, err_count
    );

    modport slave (
        input  rx_data, rx_valid, rx_perror, rx_ferror,
        output signal_to_display, display_update, error_flag,
        output timeout_pulse, word_count, err_count
    );
endinterface

// File: rtl/rx_display_sequencer.sv
// Pairs received bytes into 16-bit display words (high byte first), shows an
// error pattern on receive errors, and drops half words after an inter-byte timeout.
module rx_display_sequencer #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] ERROR_PATTERN  = 16'hEEEE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    rx_display_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        COMMIT   = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] disp_q, disp_d;
    logic        upd_q, upd_d;
    logic        errf_q, errf_d;
    logic        to_q, to_d;
    logic [7:0]  wc_q, wc_d;
    logic [7:0]  ec_q, ec_d;

    logic        byte_good_s;
    logic        byte_err_s;

    assign byte_err_s  = bus.rx_valid & (bus.rx_perror | bus.rx_ferror);
    assign byte_good_s = bus.rx_valid & ~(bus.rx_perror | bus.rx_ferror);

    // Next-state and datapath: commit/error side effects first, then byte intake.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        timer_d = timer_q;
        disp_d  = disp_q;
        upd_d   = 1'b0;
        errf_d  = errf_q;
        to_d    = 1'b0;
        wc_d    = wc_q;
        ec_d    = ec_q;

        if (clear) begin
            // Same effect as reset; a byte strobed alongside clear is dropped.
            state_d = IDLE;
            hi_d    = 8'h00;
            lo_d    = 8'h00;
            timer_d = 16'h0000;
            disp_d  = 16'h0000;
            errf_d  = 1'b0;
            wc_d    = 8'h00;
            ec_d    = 8'h00;
        end else begin
            case (state_q)
                WAIT_LOW: begin
                    if (byte_good_s) begin
                        lo_d    = bus.rx_data;
                        state_d = COMMIT;
                    end else if (byte_err_s) begin
                        hi_d    = 8'h00;
                        state_d = ERROR;
                    end else if (timer_q == TIMER_LAST) begin
                        hi_d    = 8'h00;
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                IDLE, COMMIT, ERROR: begin
                    if (state_q == COMMIT) begin
                        disp_d = {hi_q, lo_q};
                        upd_d  = 1'b1;
                        errf_d = 1'b0;
                        wc_d   = wc_q + 8'd1;
                    end else if (state_q == ERROR) begin
                        disp_d = ERROR_PATTERN;
                        upd_d  = 1'b1;
                        errf_d = 1'b1;
                        ec_d   = (ec_q == 8'hFF) ? ec_q : (ec_q + 8'd1);
                    end else begin
                        disp_d = disp_q;
                    end

                    // COMMIT and ERROR accept a new byte exactly like IDLE.
                    if (byte_good_s) begin
                        hi_d    = bus.rx_data;
                        timer_d = 16'h0000;
                        state_d = WAIT_LOW;
                    end else if (byte_err_s) begin
                        state_d = ERROR;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            timer_q <= 16'h0000;
            disp_q  <= 16'h0000;
            upd_q   <= 1'b0;
            errf_q  <= 1'b0;
            to_q    <= 1'b0;
            wc_q    <= 8'h00;
            ec_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            timer_q <= timer_d;
            disp_q  <= disp_d;
            upd_q   <= upd_d;
            errf_q  <= errf_d;
            to_q    <= to_d;
            wc_q    <= wc_d;
            ec_q    <= ec_d;
        end
    end

    assign bus.signal_to_display = disp_q;
    assign bus.display_update    = upd_q;
    assign bus.error_flag        = errf_q;
    assign bus.timeout_pulse     = to_q;
    assign bus.word_count        = wc_q;
    assign bus.err_count         = ec_q;

endmodule
